alu_ctrl_seq: RTL and testbench
===============================

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter OPW, default 4: opcode width.
REQ-002 Parameter FW, default 2: funct width.
REQ-003 Parameter CTLW, default 5: ALU control code width, >= 5.
REQ-004 Parameter DATA_W, default 16: datapath width; sets MUL step count and shamt width SW = clog2(DATA_W).
REQ-005 Ports SHALL be:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  decode request.
- in_ready  out  1  request accepted when in_valid && in_ready.
- alu_op  in  2  00 LW/SW, 01 BEQ, 10 R-format, 11 I-format.
- funct  in  FW  function field.
- opcode  in  OPW  opcode field.
- shamt  in  SW  shift amount for SLL/SRA.
- alu_ctrl  out  CTLW  registered ALU control code.
- step  out  1  one pulse per iteration of a multi-cycle op.
- last  out  1  marks the final step.
- out_valid  out  1  operation complete; alu_ctrl and illegal are final.
- out_ready  in  1  consumer accepts completion.
- illegal  out  1  the captured request is undecodable.

Function
REQ-006 Decode table:
- alu_op 00: ADD 0x04.
- alu_op 01: SUB 0x0C.
- alu_op 10, funct 00: opcode 0000 AND 0x00; opcode 0001 ADD 0x04.
- alu_op 10, funct 01: opcode 0000 OR 0x02; opcode 0001 SUB 0x0C.
- alu_op 10, funct 10: XOR 0x03 for any opcode.
- alu_op 10, funct 11, opcode 0000: MUL 0x10.
- alu_op 11: opcode 1001 ADDI 0x04; 1010 SUBI 0x0D; 1011 SLTI 0x01.
- alu_op 11, opcode 0010: funct 00 SLL 0x06; funct 01 SRA 0x07.
REQ-007 Every other combination SHALL decode to illegal = 1, alu_ctrl = 0x1F, and be treated as single-cycle.
REQ-008 Codes SHALL be zero-extended to CTLW; the decoder output SHALL be fully specified, with no latched or undefined value.
REQ-009 FSM states SHALL be IDLE, ITER and DONE.
REQ-010 in_ready SHALL be 1 only in IDLE.
REQ-011 Requests presented in ITER or DONE SHALL be ignored and have no effect.
REQ-012 On acceptance, alu_ctrl and illegal SHALL be registered and held until the next acceptance or reset.
REQ-013 Single-cycle ops SHALL go IDLE->DONE, so out_valid = 1 the cycle after acceptance.
REQ-014 Iteration count N SHALL be:
- MUL: N = DATA_W.
- SLL/SRA: N = shamt; shamt = 0 is treated as single-cycle.
REQ-015 Multi-cycle ops SHALL go IDLE->ITER and load a down-counter with N-1.
REQ-016 In ITER, step SHALL be 1 every cycle, the counter SHALL decrement, and last SHALL be 1 when the counter = 0.
REQ-017 ITER SHALL go to DONE after the last step, so out_valid rises N+1 cycles after acceptance.
REQ-018 out_valid SHALL be 1 only in DONE and SHALL hold until out_ready = 1.
REQ-019 DONE with out_ready = 1 SHALL return to IDLE on the next cycle.
REQ-020 out_ready SHALL be ignored outside DONE.
REQ-021 step and last SHALL be 0 outside ITER.
REQ-022 Maximum throughput SHALL be one single-cycle op per 2 cycles.

Reset
REQ-023 While rst_n = 0 at a clock edge, the block SHALL enter IDLE with:
- counter = 0, alu_ctrl = 0, illegal = 0.
- out_valid = 0, step = 0, last = 0.
- in_ready = 1 on the first cycle after rst_n returns to 1.
REQ-024 Reset asserted in ITER or DONE SHALL abort the operation, and no out_valid SHALL be produced for it.

Structure
REQ-025 Package alu_ctrl_pkg SHALL hold the ALU control code constants, the alu_op encodings, and the FSM state type.
REQ-026 Decoding SHALL live in combinational sub-module alu_ctrl_dec.
- Outputs: code, illegal, multi-cycle flag, N.
- alu_ctrl_seq instantiates it and owns the FSM and counter.

Verification
REQ-027 Decode sweep: every alu_op/funct/opcode combination, out_ready = 1 -> alu_ctrl matches REQ-006/REQ-007; out_valid one cycle after each accept; no step pulses.
REQ-028 MUL: alu_op 10, funct 11, opcode 0000, DATA_W = 16 -> 16 step pulses; last on the 16th; out_valid on cycle 17; alu_ctrl = 0x10.
REQ-029 SRA shamt = 3 -> 3 steps, last on the 3rd, alu_ctrl = 0x07. SLL shamt = 0 -> no steps, out_valid next cycle, alu_ctrl = 0x06.
REQ-030 Backpressure: out_ready = 0 for 5 cycles in DONE -> out_valid and alu_ctrl stable, in_ready = 0, a new in_valid is ignored; out_ready = 1 -> IDLE next cycle.
REQ-031 Reset mid-ITER: rst_n = 0 at MUL step 7 -> next cycle all outputs 0, in_ready = 1 after release, no out_valid for the aborted op.
REQ-032 Illegal request: alu_op 11, opcode 1111 -> illegal = 1, alu_ctrl = 0x1F, out_valid next cycle; a following legal ADDI clears illegal.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control sequencer: control codes, alu_op
// encodings, fixed opcode/funct patterns and the sequencer state type.
package alu_ctrl_pkg;

  // ALU control codes (5-bit, zero-extended to CTLW at the decoder output)
  localparam logic [4:0] CTL_AND     = 5'h00;
  localparam logic [4:0] CTL_SLT     = 5'h01;
  localparam logic [4:0] CTL_OR      = 5'h02;
  localparam logic [4:0] CTL_XOR     = 5'h03;
  localparam logic [4:0] CTL_ADD     = 5'h04;
  localparam logic [4:0] CTL_SLL     = 5'h06;
  localparam logic [4:0] CTL_SRA     = 5'h07;
  localparam logic [4:0] CTL_SUB     = 5'h0C;
  localparam logic [4:0] CTL_SUBI    = 5'h0D;
  localparam logic [4:0] CTL_MUL     = 5'h10;
  localparam logic [4:0] CTL_ILLEGAL = 5'h1F;

  // alu_op encodings
  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  // Opcode and funct patterns used by the decode table
  localparam logic [3:0] OPC_0000 = 4'b0000;
  localparam logic [3:0] OPC_0001 = 4'b0001;
  localparam logic [3:0] OPC_SHIFT = 4'b0010;
  localparam logic [3:0] OPC_ADDI = 4'b1001;
  localparam logic [3:0] OPC_SUBI = 4'b1010;
  localparam logic [3:0] OPC_SLTI = 4'b1011;

  localparam logic [1:0] FN_00 = 2'b00;
  localparam logic [1:0] FN_01 = 2'b01;
  localparam logic [1:0] FN_10 = 2'b10;
  localparam logic [1:0] FN_11 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_ctrl_if.sv
// Request/completion bundle between a requester (master) and the sequencer (slave).
interface alu_ctrl_if #(
  parameter int OPW    = 4,
  parameter int FW     = 2,
  parameter int CTLW   = 5,
  parameter int DATA_W = 16
);
  localparam int SW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [FW-1:0]   funct;
  logic [OPW-1:0]  opcode;
  logic [SW-1:0]   shamt;
  logic [CTLW-1:0] alu_ctrl;
  logic            step;
  logic            last;
  logic            out_valid;
  logic            out_ready;
  logic            illegal;

  modport master (
    output in_valid, alu_op, funct, opcode, shamt, out_ready,
    input  in_ready, alu_ctrl, step, last, out_valid, illegal
  );

  modport slave (
    input  in_valid, alu_op, funct, opcode, shamt, out_ready,
    output in_ready, alu_ctrl, step, last, out_valid, illegal
  );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational decoder: alu_op/funct/opcode/shamt -> control code, illegal
// flag, multi-cycle flag and iteration count. Anything not in the table
// decodes to the illegal code and is single-cycle.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
#(
  parameter int OPW    = 4,
  parameter int FW     = 2,
  parameter int CTLW   = 5,
  parameter int DATA_W = 16,
  localparam int SW    = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic [1:0]      alu_op_i,
  input  logic [FW-1:0]   funct_i,
  input  logic [OPW-1:0]  opcode_i,
  input  logic [SW-1:0]   shamt_i,
  output logic [CTLW-1:0] code_o,
  output logic            illegal_o,
  output logic            multi_o,
  output logic [SW:0]     n_o
);

  logic [4:0] code5;

  // Table decode with illegal defaults so every path is fully specified
  always_comb begin
    code5     = CTL_ILLEGAL;
    illegal_o = 1'b1;
    multi_o   = 1'b0;
    n_o       = '0;
    unique case (alu_op_i)
      ALUOP_MEM: begin
        code5 = CTL_ADD; illegal_o = 1'b0;
      end
      ALUOP_BEQ: begin
        code5 = CTL_SUB; illegal_o = 1'b0;
      end
      ALUOP_RTYPE: begin
        if (funct_i == FW'(FN_00)) begin
          if (opcode_i == OPW'(OPC_0000)) begin
            code5 = CTL_AND; illegal_o = 1'b0;
          end else if (opcode_i == OPW'(OPC_0001)) begin
            code5 = CTL_ADD; illegal_o = 1'b0;
          end
        end else if (funct_i == FW'(FN_01)) begin
          if (opcode_i == OPW'(OPC_0000)) begin
            code5 = CTL_OR; illegal_o = 1'b0;
          end else if (opcode_i == OPW'(OPC_0001)) begin
            code5 = CTL_SUB; illegal_o = 1'b0;
          end
        end else if (funct_i == FW'(FN_10)) begin
          code5 = CTL_XOR; illegal_o = 1'b0;
        end else if (funct_i == FW'(FN_11) && opcode_i == OPW'(OPC_0000)) begin
          code5     = CTL_MUL;
          illegal_o = 1'b0;
          multi_o   = 1'b1;
          n_o       = (SW+1)'(DATA_W);
        end
      end
      ALUOP_ITYPE: begin
        if (opcode_i == OPW'(OPC_ADDI)) begin
          code5 = CTL_ADD; illegal_o = 1'b0;
        end else if (opcode_i == OPW'(OPC_SUBI)) begin
          code5 = CTL_SUBI; illegal_o = 1'b0;
        end else if (opcode_i == OPW'(OPC_SLTI)) begin
          code5 = CTL_SLT; illegal_o = 1'b0;
        end else if (opcode_i == OPW'(OPC_SHIFT) &&
                     (funct_i == FW'(FN_00) || funct_i == FW'(FN_01))) begin
          code5     = (funct_i == FW'(FN_00)) ? CTL_SLL : CTL_SRA;
          illegal_o = 1'b0;
          // a zero shift has nothing to iterate over
          multi_o   = (shamt_i != '0);
          n_o       = {1'b0, shamt_i};
        end
      end
      default: ;
    endcase
    code_o = CTLW'(code5);
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: captures a decoded request, paces multi-cycle ops
// with step/last pulses from a down-counter, then holds the result until
// the consumer takes it.
//
//   state | meaning
//   IDLE  | ready for a request (in_ready = 1)
//   ITER  | multi-cycle op running, one step per cycle, last at count 0
//   DONE  | result valid, waiting for out_ready
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OPW    = 4,
  parameter int FW     = 2,
  parameter int CTLW   = 5,
  parameter int DATA_W = 16,
  localparam int SW    = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input logic       clk,
  input logic       rst_n,
  alu_ctrl_if.slave bus
);

  state_t          state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [CTLW-1:0] ctrl_q, ctrl_d;
  logic            ill_q, ill_d;

  logic [CTLW-1:0] dec_code;
  logic            dec_illegal;
  logic            dec_multi;
  logic [SW:0]     dec_n;
  logic            accept;

  alu_ctrl_dec #(
    .OPW(OPW), .FW(FW), .CTLW(CTLW), .DATA_W(DATA_W)
  ) u_dec (
    .alu_op_i (bus.alu_op),
    .funct_i  (bus.funct),
    .opcode_i (bus.opcode),
    .shamt_i  (bus.shamt),
    .code_o   (dec_code),
    .illegal_o(dec_illegal),
    .multi_o  (dec_multi),
    .n_o      (dec_n)
  );

  assign accept = bus.in_valid && (state_q == ST_IDLE);

  // State, counter and captured result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      ill_q   <= ill_d;
    end
  end

  // Next state, counter load/decrement and result capture on acceptance
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    ill_d   = ill_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ctrl_d = dec_code;
          ill_d  = dec_illegal;
          if (dec_multi) begin
            state_d = ST_ITER;
            cnt_d   = SW'(dec_n - 1'b1);
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_ITER: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and step outputs decoded from the current state
  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.out_valid = (state_q == ST_DONE);
    bus.step      = (state_q == ST_ITER);
    bus.last      = (state_q == ST_ITER) && (cnt_q == '0);
    bus.alu_ctrl  = ctrl_q;
    bus.illegal   = ill_q;
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq with a queue scoreboard of expected results.
module tb_alu_ctrl_seq;

  localparam int OPW = 4, FW = 2, CTLW = 5, DATA_W = 16;

  typedef struct {
    logic [4:0] ctrl;
    logic       ill;
    int         steps;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  alu_ctrl_if #(.OPW(OPW), .FW(FW), .CTLW(CTLW), .DATA_W(DATA_W)) bus ();

  alu_ctrl_seq #(.OPW(OPW), .FW(FW), .CTLW(CTLW), .DATA_W(DATA_W)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decode table
  function automatic void model(input int op, input int f, input int oc,
                                output logic [4:0] c, output logic il, output int n);
    c = 5'h1F; il = 1'b1; n = 0;
    case (op)
      0: begin c = 5'h04; il = 1'b0; end
      1: begin c = 5'h0C; il = 1'b0; end
      2: begin
        if (f == 0 && oc == 0) begin c = 5'h00; il = 1'b0; end
        if (f == 0 && oc == 1) begin c = 5'h04; il = 1'b0; end
        if (f == 1 && oc == 0) begin c = 5'h02; il = 1'b0; end
        if (f == 1 && oc == 1) begin c = 5'h0C; il = 1'b0; end
        if (f == 2)            begin c = 5'h03; il = 1'b0; end
        if (f == 3 && oc == 0) begin c = 5'h10; il = 1'b0; n = 16; end
      end
      default: begin
        if (oc == 9)           begin c = 5'h04; il = 1'b0; end
        if (oc == 10)          begin c = 5'h0D; il = 1'b0; end
        if (oc == 11)          begin c = 5'h01; il = 1'b0; end
        if (oc == 2 && f == 0) begin c = 5'h06; il = 1'b0; end
        if (oc == 2 && f == 1) begin c = 5'h07; il = 1'b0; end
      end
    endcase
  endfunction

  task automatic drive(input int op, input int f, input int oc, input int sh);
    bus.in_valid = 1'b1;
    bus.alu_op   = op[1:0];
    bus.funct    = f[1:0];
    bus.opcode   = oc[3:0];
    bus.shamt    = sh[3:0];
  endtask

  // Issue one request with out_ready high, track steps until completion
  task automatic do_op(input int op, input int f, input int oc, input int sh,
                       input logic [4:0] ectl, input logic eil, input int esteps,
                       input string tag);
    exp_t e;
    int   steps_seen, last_at, cyc;
    bit   got;
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    drive(op, f, oc, sh);
    e.ctrl = ectl; e.ill = eil; e.steps = esteps;
    sb.push_back(e);
    tick();
    bus.in_valid = 1'b0;
    steps_seen = 0; last_at = -1; got = 1'b0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      if (bus.out_valid) begin got = 1'b1; break; end
      if (bus.step) begin
        steps_seen++;
        if (bus.last) last_at = steps_seen;
      end else if (bus.last) begin
        last_at = -2;
      end
      tick();
    end
    e = sb.pop_front();
    if (!got) begin
      chk({tag, "_timeout"}, {31'd0, bus.out_valid}, 32'd1);
      return;
    end
    chk({tag, "_latency"}, cyc, e.steps + 1);
    chk({tag, "_steps"}, steps_seen, e.steps);
    chk({tag, "_last"}, last_at, (e.steps > 0) ? e.steps : -1);
    chk({tag, "_ctrl"}, {27'd0, bus.alu_ctrl}, {27'd0, e.ctrl});
    chk({tag, "_illegal"}, {31'd0, bus.illegal}, {31'd0, e.ill});
    tick();
    chk({tag, "_idle_ov"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin : stim
    logic [4:0] mc;
    logic       mi;
    int         mn;
    exp_t       e;
    bit         seen;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.alu_op = '0; bus.funct = '0;
    bus.opcode = '0; bus.shamt = '0; bus.out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_step", {31'd0, bus.step}, 32'd0);
    chk("rst_last", {31'd0, bus.last}, 32'd0);
    chk("rst_ctrl", {27'd0, bus.alu_ctrl}, 32'd0);
    chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // full decode sweep with zero shift amount
    for (int op = 0; op < 4; op++)
      for (int f = 0; f < 4; f++)
        for (int oc = 0; oc < 16; oc++) begin
          model(op, f, oc, mc, mi, mn);
          do_op(op, f, oc, 0, mc, mi, mn, $sformatf("sweep_%0d_%0d_%0d", op, f, oc));
        end

    do_op(2, 3, 0, 0, 5'h10, 1'b0, 16, "mul");
    do_op(3, 1, 2, 3, 5'h07, 1'b0, 3, "sra3");
    do_op(3, 0, 2, 0, 5'h06, 1'b0, 0, "sll0");
    do_op(3, 0, 2, 1, 5'h06, 1'b0, 1, "sll1");
    do_op(3, 0, 2, 15, 5'h06, 1'b0, 15, "sll15");

    // backpressure in DONE with an ignored request
    bus.out_ready = 1'b0;
    drive(0, 0, 0, 0);
    e.ctrl = 5'h04; e.ill = 1'b0; e.steps = 0;
    sb.push_back(e);
    tick();
    bus.alu_op = 2'b01;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_ctrl", {27'd0, bus.alu_ctrl}, 32'h04);
      tick();
    end
    bus.in_valid = 1'b0;
    e = sb.pop_front();
    chk("bp_sb_ctrl", {27'd0, bus.alu_ctrl}, {27'd0, e.ctrl});
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_ov", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("bp_release_ctrl", {27'd0, bus.alu_ctrl}, 32'h04);

    // reset during MUL at step 7
    drive(2, 3, 0, 0);
    e.ctrl = 5'h10; e.ill = 1'b0; e.steps = 16;
    sb.push_back(e);
    tick();
    bus.in_valid = 1'b0;
    repeat (6) tick();
    chk("abort_step7", {31'd0, bus.step}, 32'd1);
    rst_n = 1'b0;
    tick();
    sb.delete();
    chk("abort_step", {31'd0, bus.step}, 32'd0);
    chk("abort_last", {31'd0, bus.last}, 32'd0);
    chk("abort_ov", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_ctrl", {27'd0, bus.alu_ctrl}, 32'd0);
    chk("abort_illegal", {31'd0, bus.illegal}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    chk("abort_no_ov", {31'd0, seen}, 32'd0);

    // illegal request then a legal ADDI
    do_op(3, 0, 15, 0, 5'h1F, 1'b1, 0, "illegal");
    do_op(3, 0, 9, 0, 5'h04, 1'b0, 0, "addi_after_illegal");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
